// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Pointer and flag controller for a synchronous FIFO. Sits directly upstream
//   of the FIFO memory. It turns raw producer/consumer requests into guarded
//   memory strobes and wrap-bit pointers. It also derives every status flag
//   from the registered pointers.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   wr_en        in   1      producer write request
//   rd_en        in   1      consumer read request
//   clr_err      in   1      synchronous clear of overflow/underflow
//   cw_en        out  1      guarded write strobe to memory
//   cr_en        out  1      guarded read strobe to memory
//   w_ptr        out  FAS+1  write pointer {wrap, addr}
//   r_ptr        out  FAS+1  read pointer {wrap, addr}
//   full         out  1      FIFO holds MEMORY_DEPTH entries
//   empty        out  1      FIFO holds 0 entries
//   almost_full  out  1      count >= AF_THRESH
//   almost_empty out  1      count <= AE_THRESH
//   count        out  FAS+1  occupancy, 0..MEMORY_DEPTH
//   rdata_valid  out  1      memory read data valid this cycle
//   overflow     out  1      sticky: write requested while full
//   underflow    out  1      sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int MEMORY_DEPTH      = 4,
  parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
  parameter int AF_THRESH         = MEMORY_DEPTH - 1,
  parameter int AE_THRESH         = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic                         clr_err,
  output logic                         cw_en,
  output logic                         cr_en,
  output logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
  output logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [FIFO_ADDRESS_SIZE:0]   count,
  output logic                         rdata_valid,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = FIFO_ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_rvld_p1;
  logic          r_ovf;
  logic          r_udf;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_cw_en;
  logic          w_cr_en;
  logic          w_ovf_set;
  logic          w_udf_set;

  // Status is a pure function of the registered pointers. No request input
  // reaches a flag combinationally.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_ADDRESS_SIZE] != r_rptr[FIFO_ADDRESS_SIZE]) &&
                   (r_wptr[FIFO_ADDRESS_SIZE-1:0] == r_rptr[FIFO_ADDRESS_SIZE-1:0]);

  // Guarded strobes. There is no pass-through, so a read on an empty FIFO is
  // refused even when a write arrives in the same cycle (and vice versa on full).
  assign w_cw_en = wr_en & ~w_full;
  assign w_cr_en = rd_en & ~w_empty;

  // A read that arrives together with a write on an empty FIFO is only a
  // stall: the data is on its way, so it is not counted as underflow.
  // A write on a full FIFO is always an overflow, even when a read frees a
  // slot in the same cycle.
  assign w_ovf_set = wr_en & w_full;
  assign w_udf_set = rd_en & w_empty & ~wr_en;

  // ---- stage p0 -> p1 : pointer, valid and sticky-error registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rvld_p1 <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_cw_en) r_wptr <= r_wptr + PTR_ONE;
      if (w_cr_en) r_rptr <= r_rptr + PTR_ONE;
      // The data returns one cycle after the read, in step with the memory's read flop.
      r_rvld_p1 <= w_cr_en;
      // If a set and clr_err happen in the same cycle, the set wins.
      r_ovf     <= w_ovf_set | (r_ovf & ~clr_err);
      r_udf     <= w_udf_set | (r_udf & ~clr_err);
    end
  end

  assign cw_en        = w_cw_en;
  assign cr_en        = w_cr_en;
  assign w_ptr        = r_wptr;
  assign r_ptr        = r_rptr;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_LVL);
  assign almost_empty = (w_count <= AE_LVL);
  assign rdata_valid  = r_rvld_p1;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//   Scoreboard bench for fifo_ctrl (DEPTH=4, AF=3, AE=1). The driver applies
//   requests and pushes the expected observable state for each cycle. The
//   reference model is a queue of entry tags plus running write/read totals.
//   A monitor pops the expectations and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int D   = 4;
  localparam int FAS = 2;
  localparam int AF  = 3;
  localparam int AE  = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic           rd_en = 1'b0;
  logic           clr_err = 1'b0;
  logic           cw_en, cr_en, full, empty, almost_full, almost_empty;
  logic           rdata_valid, overflow, underflow;
  logic [FAS:0]   w_ptr, r_ptr, count;

  fifo_ctrl #(
    .MEMORY_DEPTH(D), .FIFO_ADDRESS_SIZE(FAS), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .cw_en(cw_en), .cr_en(cr_en), .w_ptr(w_ptr), .r_ptr(r_ptr),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .rdata_valid(rdata_valid),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cw, cr, full, empty, af, ae, rv, ovf, udf;
    int cnt, wp, rp;
  } exp_t;

  exp_t sbq[$];
  int   rdq[$];
  int   mq[$];
  int   wtot = 0, rtot = 0, tag = 0;
  bit   ovf = 0, udf = 0, rv = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus. The expectation holds for the window after this
  // drive point; the model then advances across the coming rising edge.
  task automatic step(input bit rst, input bit wr, input bit rd, input bit clr);
    exp_t e;
    int   n;
    bit   aw, ar;
    @(posedge clk);
    #2;
    if (rst) begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      wr = 0; rd = 0; clr = 0;
      mq.delete(); rdq.delete();
      wtot = 0; rtot = 0; ovf = 0; udf = 0; rv = 0;
    end else begin
      rst_n = 1'b1; wr_en = wr; rd_en = rd; clr_err = clr;
    end
    n  = mq.size();
    aw = wr && (n < D);
    ar = rd && (n > 0);
    e.cw = aw;  e.cr = ar;  e.cnt = n;
    e.wp = wtot % (2 * D);  e.rp = rtot % (2 * D);
    e.full = (n == D);  e.empty = (n == 0);
    e.af = (n >= AF);   e.ae = (n <= AE);
    e.rv = rv;  e.ovf = ovf;  e.udf = udf;
    sbq.push_back(e);
    if (!rst) begin
      ovf = (wr && n == D) || (ovf && !clr);
      udf = (rd && n == 0 && !wr) || (udf && !clr);
      if (ar) begin rdq.push_back(mq.pop_front()); rtot++; end
      if (aw) begin mq.push_back(tag); tag++; wtot++; end
      rv = ar;
    end
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("cw_en",        cw_en,        e.cw);
        chk("cr_en",        cr_en,        e.cr);
        chk("count",        count,        e.cnt);
        chk("w_ptr",        w_ptr,        e.wp);
        chk("r_ptr",        r_ptr,        e.rp);
        chk("full",         full,         e.full);
        chk("empty",        empty,        e.empty);
        chk("almost_full",  almost_full,  e.af);
        chk("almost_empty", almost_empty, e.ae);
        chk("rdata_valid",  rdata_valid,  e.rv);
        chk("overflow",     overflow,     e.ovf);
        chk("underflow",    underflow,    e.udf);
      end
      if (rdata_valid === 1'b1) begin
        chk("rvalid_has_read", rdq.size() > 0, 1);
        if (rdq.size() > 0) void'(rdq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, then idle after release
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // 2: four single writes
    repeat (4) step(0, 1, 0, 0);
    // 3: fifth write while full, then clear the error
    step(0, 1, 0, 0);
    @(negedge clk);
    chk("t3_cw_blocked", cw_en, 0);
    chk("t3_wptr_full",  w_ptr, 4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // 4: drain four entries, then read once more on empty
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    // 5: fill to two, then simultaneous requests for ten cycles
    repeat (2) step(0, 1, 0, 0);
    repeat (10) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    // 6: both requests on empty, then both on full
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    // mid-operation reset while partially full
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // randomized segments with varying request density
    for (int seg = 0; seg < 15; seg++) begin
      int pw, pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr,
             $urandom_range(0, 15) == 0);
    end
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
